sr_latch_ctrl: RTL
==================

# sr_latch_ctrl

Synchronous controller that owns one external SR latch (the NAND `srlatch` cell with `s`, `r`, `q`, `qbar`) and shares it among several requesters. Requesters ask for a set or a reset. A round-robin arbiter picks one request at a time. An FSM drives a clean, width-controlled `s` or `r` pulse, never both at once, and can optionally confirm the result on the latch's `q` feedback before it acknowledges. The block sits between the status/flag logic that issues requests and the latch cell itself.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- PULSE_W, 2, cycles `s`/`r` held high per operation (>=1)
- SETTLE, 3, maximum CHECK cycles waiting for `q` to match (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level, held until its `ack`
- op  in  NREQ  per-requester operation, 1=set, 0=reset; stable while `req` is high
- q  in  1  latch output feedback, asynchronous to `clk`
- err_clr  in  1  synchronous clear of `err`
- s  out  1  latch set drive, registered
- r  out  1  latch reset drive, registered
- ack  out  NREQ  one-hot, one-cycle completion pulse
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky: the latch failed to reach the requested value

## Operation
- States: IDLE, DRIVE, CHECK, ACK.
- IDLE:
  - If any `req` bit is high, the arbiter grants the first requesting index at or after `ptr` (wrapping modulo NREQ).
  - The grant index `g` and `op[g]` are registered.
  - Next state is DRIVE, with `s`=op[g] and `r`=~op[g].
- DRIVE:
  - Holds the drive for PULSE_W cycles using a pulse counter.
  - On exit, `s` and `r` both go to 0.
  - Exits to CHECK, or to ACK when verification is compiled out.
- CHECK:
  - Compares `q_sync` (a 2-flop synchronizer on `q`) with the registered op.
  - On a match, goes to ACK.
  - After SETTLE cycles with no match, sets `err` and goes to ACK anyway.
- ACK:
  - `ack[g]`=1 for exactly one cycle.
  - `ptr` becomes (g+1) mod NREQ.
  - Next state is IDLE.
- Invariant: `s & r` is never 1. At least one cycle with both low separates any two drive pulses.
- A redundant operation (latch already in the requested state) is still driven and acknowledged normally.
- Deasserting `req[g]` mid-operation does not abort it; `ack[g]` still pulses.
- A requester still holding `req` in the cycle after its `ack` is treated as a new request. Round-robin order means the other requesters are served first.
- `err_clr` and a new error in the same cycle: the set wins, so `err` stays 1.
- Reset values: `s`=0, `r`=0, `ack`=0, `busy`=0, `err`=0, `ptr`=0, state=IDLE, synchronizer flops=0.
- Asserting `rst` mid-operation forces `s`/`r` low immediately (asynchronous). No `ack` is issued for the aborted operation.

## Timing
- `req` is sampled in an IDLE cycle t.
- `s`/`r` are high in cycles t+1 .. t+PULSE_W.
- CHECK starts at t+PULSE_W+1.
- With the latch responding within a cycle and PULSE_W>=2, `ack` is high in cycle t+PULSE_W+2. With the defaults, that is t+4.
- Timeout path: `ack` in cycle t+PULSE_W+SETTLE+1, and `err` is high from that same cycle.
- Without verification: `ack` in cycle t+PULSE_W+1.
- Back-to-back throughput is one operation per PULSE_W+3 cycles, including the IDLE cycle.

## Configuration
- `SR_LATCH_CTRL_VERIFY_EN` defined:
  - CHECK state, `q` synchronizer and SETTLE timeout are present.
  - `err` is functional.
- `SR_LATCH_CTRL_VERIFY_EN` undefined:
  - DRIVE goes directly to ACK.
  - The `q` and `err_clr` ports remain but are ignored.
  - `err` is tied to 0.
  - Latency and throughput shrink by one cycle.

## Structure
- Shared package `sr_ctrl_pkg` holds:
  - the state enum (IDLE, DRIVE, CHECK, ACK);
  - op encoding constants OP_SET=1'b1, OP_RESET=1'b0.
- One sub-module, `sr_rr_arb`:
  - combinational round-robin grant from `req` and `ptr`;
  - outputs a one-hot grant and its binary index.
- The FSM, counters, synchronizer and `ptr` register live in `sr_latch_ctrl`.

## Test plan
- Single set: in IDLE with q=0, req=0001 and op=0001 → s=1 for 2 cycles (r=0 throughout), ack=0001 at t+4, q=1, err=0.
- Contention: req=1111 held with ops alternating, ptr=0 → acks in order 0001, 0010, 0100, 1000, 0001. Checker confirms s&r is never 1 and a gap cycle separates every pair of pulses.
- Stuck latch: q forced to 0, reset-then-set request → ack at t+PULSE_W+SETTLE+1, err=1 and sticky. An `err_clr` pulse then returns err to 0.
- Reset mid-DRIVE: rst asserted while s=1 → s=0 immediately, no ack, busy=0, ptr=0. After release, the same held request is re-served from the start.
- Request withdrawal: req[2] dropped during CHECK → ack=0100 still issued. No second operation for requester 2.
- Macro off: build without `SR_LATCH_CTRL_VERIFY_EN` and repeat the single set → ack at t+3, err stays 0 with q forced low.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch controller: FSM state encoding
// and the set/reset operation encoding used on the op inputs.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/sr_rr_arb.sv
// Combinational round-robin arbiter: grants the first requesting index at or
// after ptr, wrapping modulo NREQ. Returns a one-hot grant and its index.
module sr_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W:0] pos;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    pos       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(NREQ)) pos = pos - (IDX_W + 1)'(NREQ);
      if (req[pos[IDX_W-1:0]]) begin
        gnt                   = '0;
        gnt[pos[IDX_W-1:0]]   = 1'b1;
        gnt_idx               = pos[IDX_W-1:0];
        gnt_valid             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Arbitrated pulse controller for one external NAND SR latch. Define
// SR_LATCH_CTRL_VERIFY_EN to confirm q after each pulse (CHECK state, err).
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int PULSE_W = 2,
  parameter int SETTLE  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  input  logic            q,
  input  logic            err_clr,
  output logic            s,
  output logic            r,
  output logic [NREQ-1:0] ack,
  output logic            busy,
  output logic            err
);

  localparam int IDX_W   = $clog2(NREQ);
  localparam int CNT_MAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  gidx, gidx_nxt;
  logic [NREQ-1:0]   gnt_oh, gnt_oh_nxt;
  logic              op_reg, op_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              s_nxt, r_nxt;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;

  sr_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

`ifdef SR_LATCH_CTRL_VERIFY_EN
  logic [1:0] q_ff;
  logic       q_sync;
  logic       err_set;

  // q comes straight from the latch with no clock relationship.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_ff <= 2'b00;
    else     q_ff <= {q_ff[0], q};
  end
  assign q_sync = q_ff[1];

  // A fresh failure outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`else
  logic unused_inputs;
  assign unused_inputs = q ^ err_clr;
  assign err           = 1'b0;
`endif

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    gidx_nxt   = gidx;
    gnt_oh_nxt = gnt_oh;
    op_nxt     = op_reg;
    cnt_nxt    = cnt;
    s_nxt      = 1'b0;
    r_nxt      = 1'b0;
`ifdef SR_LATCH_CTRL_VERIFY_EN
    err_set    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          gidx_nxt   = arb_idx;
          gnt_oh_nxt = arb_gnt;
          op_nxt     = op[arb_idx];
          s_nxt      = (op[arb_idx] == OP_SET);
          r_nxt      = (op[arb_idx] == OP_RESET);
          cnt_nxt    = '0;
          state_nxt  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt == CNT_W'(PULSE_W - 1)) begin
          cnt_nxt = '0;
`ifdef SR_LATCH_CTRL_VERIFY_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_ACK;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
          s_nxt   = s;
          r_nxt   = r;
        end
      end
`ifdef SR_LATCH_CTRL_VERIFY_EN
      ST_CHECK: begin
        if (q_sync == op_reg) begin
          state_nxt = ST_ACK;
        end else if (cnt == CNT_W'(SETTLE - 1)) begin
          err_set   = 1'b1;
          state_nxt = ST_ACK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      ST_ACK: begin
        ptr_nxt   = (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      gidx   <= '0;
      gnt_oh <= '0;
      op_reg <= OP_RESET;
      cnt    <= '0;
      s      <= 1'b0;
      r      <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      gidx   <= gidx_nxt;
      gnt_oh <= gnt_oh_nxt;
      op_reg <= op_nxt;
      cnt    <= cnt_nxt;
      s      <= s_nxt;
      r      <= r_nxt;
    end
  end

  assign ack  = (state == ST_ACK) ? gnt_oh : '0;
  assign busy = (state != ST_IDLE);

endmodule
